// File: rtl/qsys_slave_pkg.sv
// -----------------------------------------------------------------------------
// qsys_slave_pkg
// Shared types and helpers for the Qsys Avalon-MM slave memory.
//   txn_kind_t   : classification of the request presented in a cycle
//   cnt_width()  : width of a counter that must hold 0..max_val (minimum 1 bit)
//   DBG_PREFIX   : tag prepended to debug messages (QSYS_SLAVE_DEBUG_EN builds)
// -----------------------------------------------------------------------------
package qsys_slave_pkg;

    typedef enum logic [1:0] {
        TXN_NONE = 2'd0,
        TXN_RD   = 2'd1,
        TXN_WR   = 2'd2
    } txn_kind_t;

    // A zero-valued maximum still needs one bit so the counter is declarable.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam string DBG_PREFIX = "[qsys_mem_slave]";

endpackage

// File: rtl/qsys_rd_pipe.sv
// -----------------------------------------------------------------------------
// qsys_rd_pipe
// Read-response pipeline: READ_LATENCY valid+data stages followed by the
// registered readdata/readdatavalid output. No back-pressure; every entry
// emerges exactly once, in order.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_data   : read accepted this cycle and the array word it read
//   out_valid, out_data : response presented to the master
//   idle                : no read anywhere in the pipeline or output register
// -----------------------------------------------------------------------------
module qsys_rd_pipe #(
    parameter int WIDTH        = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             idle
);

    logic [READ_LATENCY-1:0] stage_valid;
    logic [WIDTH-1:0]        stage_data [READ_LATENCY];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the shift is order-independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_data[i] <= '0;
            end
        end else begin
            stage_valid[0] <= in_valid;
            stage_data[0]  <= in_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
            out_valid <= stage_valid[READ_LATENCY-1];
            // readdata holds the last response between valid cycles.
            if (stage_valid[READ_LATENCY-1]) begin
                out_data <= stage_data[READ_LATENCY-1];
            end
        end
    end

    assign idle = ~(|stage_valid | out_valid);

endmodule

// File: rtl/qsys_mem_slave.sv
// -----------------------------------------------------------------------------
// qsys_mem_slave
// Avalon-MM slave memory with fixed read latency, programmable waitrequest
// throttling and a completion flag after NUM_TRANS accepted transactions.
// Optional build macro: QSYS_SLAVE_DEBUG_EN (simulation-only cycle counter and
// per-transaction / per-response messages; ports behave identically).
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   writedata, address       : request payload (low DEPTH_LOG2 address bits index words)
//   write, read              : request strobes, held by the master while waitrequest
//   readdata, readdatavalid  : read response, one valid cycle per accepted read
//   waitrequest              : slave stalling, request not accepted this cycle
//   done                     : NUM_TRANS accepted and no reads in flight
//   err                      : sticky, read and write seen high together
// -----------------------------------------------------------------------------
module qsys_mem_slave
    import qsys_slave_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 8,
    parameter int READ_LATENCY = 2,
    parameter int WAIT_CYCLES  = 1,
    parameter int NUM_TRANS    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      writedata,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write,
    input  logic                  read,
    output logic [WIDTH-1:0]      readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  done,
    output logic                  err
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int TXN_W  = cnt_width(NUM_TRANS);
    localparam int WAIT_W = cnt_width(WAIT_CYCLES);
    localparam logic [TXN_W-1:0]  TXN_MAX   = TXN_W'(NUM_TRANS);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;
    txn_kind_t             kind;
    logic                  accept;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [TXN_W-1:0]      txn_cnt;
    logic                  pipe_idle;

    assign word_idx = address[DEPTH_LOG2-1:0];

    // Upper address bits alias onto the same words and are intentionally ignored.
    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[ADDR_WIDTH-1:DEPTH_LOG2];
        end
    endgenerate

    // Write has priority: a simultaneous read+write performs only the write.
    // NOTE: kind gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        kind = TXN_NONE;
        if (!waitrequest) begin
            if (write) begin
                kind = TXN_WR;
            end else if (read) begin
                kind = TXN_RD;
            end
        end
    end

    assign accept      = (kind != TXN_NONE);
    assign waitrequest = (wait_cnt != '0);
    assign done        = (txn_cnt == TXN_MAX) & pipe_idle;

    // NOTE: the array has no reset; contents survive rst and only the control
    // state around it is cleared, which also lets it map onto RAM resources.
    always_ff @(posedge clk) begin
        if (kind == TXN_WR) begin
            mem[word_idx] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            txn_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
            end else if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            if (accept && (txn_cnt != TXN_MAX)) begin
                txn_cnt <= txn_cnt + 1'b1;
            end

            if (read && write) begin
                err <= 1'b1;
            end
        end
    end

    // The array is read at the accept edge; a write one cycle earlier has
    // already landed, so read-after-write needs no bypass.
    qsys_rd_pipe #(
        .WIDTH        (WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst),
        .in_valid  (kind == TXN_RD),
        .in_data   (mem[word_idx]),
        .out_valid (readdatavalid),
        .out_data  (readdata),
        .idle      (pipe_idle)
    );

`ifdef QSYS_SLAVE_DEBUG_EN
    logic [31:0]           dbg_cycle;
    logic [31:0]           dbg_rd_cycle [$];
    logic [ADDR_WIDTH-1:0] dbg_rd_addr  [$];
    logic                  dbg_done_q;

    // Simulation-only trace; in-flight bookkeeping is dropped on reset just
    // like the reads themselves.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_cycle  <= '0;
            dbg_done_q <= 1'b0;
            dbg_rd_cycle.delete();
            dbg_rd_addr.delete();
        end else begin
            dbg_cycle  <= dbg_cycle + 32'd1;
            dbg_done_q <= done;
            if (readdatavalid && (dbg_rd_cycle.size() != 0)) begin
                $display("%s cycle=%0d RDV addr=0x%0h data=0x%0h latency=%0d",
                         DBG_PREFIX, dbg_cycle, dbg_rd_addr[0], readdata,
                         dbg_cycle - dbg_rd_cycle[0]);
                void'(dbg_rd_cycle.pop_front());
                void'(dbg_rd_addr.pop_front());
            end
            if (accept) begin
                $display("%s cycle=%0d %s addr=0x%0h data=0x%0h latency=%0d",
                         DBG_PREFIX, dbg_cycle, kind.name(), address,
                         (kind == TXN_WR) ? writedata : mem[word_idx],
                         (kind == TXN_RD) ? READ_LATENCY : 0);
                if (kind == TXN_RD) begin
                    dbg_rd_cycle.push_back(dbg_cycle);
                    dbg_rd_addr.push_back(address);
                end
            end
            if (done && !dbg_done_q) begin
                $display("%s cycle=%0d DONE total_cycles=%0d",
                         DBG_PREFIX, dbg_cycle, dbg_cycle);
            end
        end
    end
`endif

endmodule

// File: tb/tb_qsys_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_qsys_mem_slave
// Directed bench for qsys_mem_slave (READ_LATENCY=2, WAIT_CYCLES=2,
// NUM_TRANS=4). Reads push their hand-computed data and due cycle into a
// scoreboard; an independent monitor pops on every readdatavalid.
// -----------------------------------------------------------------------------
module tb_qsys_mem_slave;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] address = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic        done;
    logic        err;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    exp_t        sb [$];
    int unsigned edge_no = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    qsys_mem_slave #(
        .WIDTH        (32),
        .ADDR_WIDTH   (32),
        .DEPTH_LOG2   (8),
        .READ_LATENCY (RL),
        .WAIT_CYCLES  (2),
        .NUM_TRANS    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .writedata     (writedata),
        .address       (address),
        .write         (write),
        .read          (read),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (readdatavalid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rdv", 32'd1, 32'd0);
                end else begin
                    check("rd_data", readdata, sb[0].data);
                    check("rd_latency", edge_no, sb[0].due);
                    void'(sb.pop_front());
                end
            end else if ((sb.size() != 0) && (sb[0].due < edge_no)) begin
                check("missing_rdv", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    // Called on a falling edge; presents the request and holds it until accepted.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd,
                       output int unsigned acc_edge, output int unsigned stalls);
        read      = rd;
        write     = wr;
        address   = a;
        writedata = d;
        stalls    = 0;
        for (int guard = 0; guard < 32; guard++) begin
            if (!waitrequest) break;
            stalls++;
            @(negedge clk);
        end
        if (waitrequest) begin
            check("accept_timeout", 32'd1, 32'd0);
        end
        acc_edge = edge_no;
        if (rd && !wr) begin
            sb.push_back('{data: exp_rd, due: edge_no + RL + 1});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_readdata"}, readdata, 32'd0);
        check({tag, "_readdatavalid"}, {31'd0, readdatavalid}, 32'd0);
        check({tag, "_waitrequest"}, {31'd0, waitrequest}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned a0, a1, a2, s0, s1, s2, k;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Two writes (one via an aliased address), two reads; done after the last response
        txn(1'b0, 1'b1, 32'h0000_0003, 32'hA5A5_0001, 32'h0, a0, s0);
        txn(1'b0, 1'b1, 32'h0000_0107, 32'h1111_2222, 32'h0, a0, s0);
        txn(1'b1, 1'b0, 32'h0000_0003, 32'h0, 32'hA5A5_0001, a0, s0);
        txn(1'b1, 1'b0, 32'h0000_0007, 32'h0, 32'h1111_2222, k, s0);
        idle();
        for (int i = 0; i < 4; i++) begin
            check("done_timing", {31'd0, done}, {31'd0, (edge_no == k + RL + 2)});
            if (i < 3) @(negedge clk);
        end

        // Three writes held back-to-back under throttling
        txn(1'b0, 1'b1, 32'd10, 32'hC0DE_000A, 32'h0, a0, s0);
        txn(1'b0, 1'b1, 32'd11, 32'hC0DE_000B, 32'h0, a1, s1);
        txn(1'b0, 1'b1, 32'd12, 32'hC0DE_000C, 32'h0, a2, s2);
        idle();
        check("accept_gap_1", a1 - a0, 32'd3);
        check("accept_gap_2", a2 - a0, 32'd6);
        check("stall_cycles_1", s1, 32'd2);
        check("stall_cycles_2", s2, 32'd2);
        check("done_saturated", {31'd0, done}, 32'd1);

        txn(1'b1, 1'b0, 32'd10, 32'h0, 32'hC0DE_000A, a0, s0);
        txn(1'b1, 1'b0, 32'd11, 32'h0, 32'hC0DE_000B, a0, s0);
        txn(1'b1, 1'b0, 32'd12, 32'h0, 32'hC0DE_000C, a0, s0);
        idle();
        repeat (6) @(negedge clk);

        // Simultaneous read and write: write wins, no response, err sticks
        check("err_before", {31'd0, err}, 32'd0);
        txn(1'b1, 1'b1, 32'd5, 32'h0000_1234, 32'h0, a0, s0);
        idle();
        check("err_set", {31'd0, err}, 32'd1);
        repeat (5) @(negedge clk);
        txn(1'b1, 1'b0, 32'd5, 32'h0, 32'h0000_1234, a0, s0);
        idle();
        repeat (6) @(negedge clk);
        check("err_sticky", {31'd0, err}, 32'd1);

        // Reset while a read is in flight
        txn(1'b1, 1'b0, 32'd3, 32'h0, 32'hA5A5_0001, a0, s0);
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("post_reset_err", {31'd0, err}, 32'd0);

        // Memory retained across reset
        txn(1'b1, 1'b0, 32'd3, 32'h0, 32'hA5A5_0001, a0, s0);
        idle();
        repeat (6) @(negedge clk);
        check("post_reset_done", {31'd0, done}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qsys_mem_slave.md
# qsys_mem_slave

Avalon-MM slave memory that sits directly downstream of the Qsys master physical wrapper: it consumes `writedata/address/write/read` and produces `readdata/readdatavalid/waitrequest`. It stores write data in an on-chip array, returns read data after a fixed pipeline latency, and throttles the master with programmable `waitrequest` back-pressure for performance evaluation. A transaction counter raises `done` once the expected traffic has completed.

## Interface
- `WIDTH`, 32: data width.
- `ADDR_WIDTH`, 32: address width; only the low `DEPTH_LOG2` bits are used as the word index.
- `DEPTH_LOG2`, 8: log2 of memory depth in words.
- `READ_LATENCY`, 2: cycles from accepted read to `readdatavalid`; at least 1.
- `WAIT_CYCLES`, 1: `waitrequest`-high cycles inserted after each accepted transaction; 0 disables throttling.
- `NUM_TRANS`, 16: accepted transactions (reads plus writes) before `done`.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `writedata`, in, WIDTH: write data.
- `address`, in, ADDR_WIDTH: word address.
- `write`, in, 1: write request.
- `read`, in, 1: read request.
- `readdata`, out, WIDTH: read response data.
- `readdatavalid`, out, 1: `readdata` valid this cycle.
- `waitrequest`, out, 1: slave stalling; request not accepted.
- `done`, out, 1: `NUM_TRANS` accepted and no reads in flight.
- `err`, out, 1: sticky; `read` and `write` were seen high together.

## Operation
- Accept is `(write | read) & ~waitrequest`.
- Accepted write: `mem[address[DEPTH_LOG2-1:0]] <= writedata` at that edge.
- Accepted read: the array is read at the accept edge into stage 1 of the read pipeline, which is `READ_LATENCY` stages deep with a valid bit and data per stage.
- Read after write to the same address one cycle later returns the new data.
- Simultaneous `read & write` with `~waitrequest`: the write is performed, the read is dropped, `err` is set, and the event counts as one transaction.
- Throttle: `wait_cnt` register, and `waitrequest = (wait_cnt != 0)`.
  - On accept, `wait_cnt <= WAIT_CYCLES`.
  - Otherwise it decrements when nonzero.
  - The request is not accepted while `waitrequest` is high; the master must hold it.
- Transaction counter `txn_cnt`, width `$clog2(NUM_TRANS+1)`, increments per accept and saturates at `NUM_TRANS`. Accepts beyond that are still serviced.
- `done = (txn_cnt == NUM_TRANS) & ~|pipe_valid`. With `NUM_TRANS = 0`, `done` is high from reset.
- The read pipeline has no back-pressure. `readdatavalid` is asserted for exactly one cycle per accepted read, in order.
- Memory contents are not reset.

## Timing
- Reset values: `readdata = 0`, `readdatavalid = 0`, `waitrequest = 0`, `done = (NUM_TRANS == 0)`, `err = 0`. All pipeline valids, `wait_cnt` and `txn_cnt` are 0.
- Read accepted at edge N: `readdatavalid` and `readdata` are valid in the cycle after edge `N+READ_LATENCY`.
- Back-to-back throughput: one accept every `WAIT_CYCLES+1` cycles.
- Reset asserted mid-operation: in-flight reads are discarded and do not appear after reset. `err` and `txn_cnt` clear. Memory retains its data.

## Configuration
- `QSYS_SLAVE_DEBUG_EN` defined: adds a free-running 32-bit cycle counter (simulation only) and a `$display` per accept and per `readdatavalid`. Each message carries the cycle, the transaction type, the address, the data, and the read latency in cycles.
- With `QSYS_SLAVE_DEBUG_EN` defined, `$display` also prints the final cycle count when `done` rises.
- `QSYS_SLAVE_DEBUG_EN` undefined: no counter and no messages. Port behaviour is identical in both builds.

## Structure
- Package `qsys_slave_pkg` holds:
  - the `txn_kind_t` enum (`TXN_NONE`, `TXN_RD`, `TXN_WR`);
  - a `clog2`-based counter-width helper;
  - the debug message prefix constant.
- Sub-module `qsys_rd_pipe` is a parameterised valid+data shift register (`WIDTH`, `READ_LATENCY`) with async active-low reset. It provides the `~|pipe_valid` status.

## Test plan
- Write `0xA5A5_0001` to address 3. Read address 3 with `READ_LATENCY=2`. Required: `readdatavalid` high exactly 2 cycles after the read accept, with `readdata = 0xA5A5_0001`.
- `WAIT_CYCLES=2`, 3 writes held continuously. Required: accepts at cycles 0, 3 and 6, and `waitrequest` high for 2 cycles after each.
- `NUM_TRANS=4`: 2 writes, then 2 reads. Required: `done` rises in the cycle after the second read's `readdatavalid` cycle, not at the 4th accept.
- Assert `read=1` and `write=1` together with address 5 and data `0x1234`. Required:
  - `err` sticks at 1;
  - no `readdatavalid`;
  - a later read of address 5 returns `0x1234`.
- Address `0x0000_0107` with `DEPTH_LOG2=8` aliases to word 7. Required: a write to `0x107` followed by a read of `0x7` returns the same data.
- Assert `rst` low one cycle after a read accept. Required: no `readdatavalid` afterward, and all outputs at their reset values.
